// File: rtl/uart2wifi_core_infra.sv
// UART-to-WiFi shared infrastructure: config register file,
// 16x baud tick generator and FWFT byte FIFO.
module uart2wifi_core_infra #(
  parameter int REG_WIDTH  = 32,
  parameter int NUM_REGS   = 3,
  parameter int BAUD_DIV   = 163,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_AW    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            reg_addr,
  input  logic [REG_WIDTH-1:0]  reg_wdata,
  input  logic                  reg_write,
  input  logic                  reg_read,
  output logic [REG_WIDTH-1:0]  reg_rdata,
  output logic                  baud_tick,
  input  logic                  wr,
  input  logic                  rd,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  empty,
  output logic                  full
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int CW    = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] C_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] C_PRE  = CW'(BAUD_DIV - 2);
  localparam logic [2:0]    C_NR   = 3'(NUM_REGS);

  logic [REG_WIDTH-1:0] r_regs [NUM_REGS];
  logic                 w_addr_ok;

  assign w_addr_ok = ({1'b0, reg_addr} < C_NR);
  assign reg_rdata = (reg_read && w_addr_ok) ?
                     r_regs[reg_addr] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++)
        r_regs[i] <= '0;
    end else if (reg_write && w_addr_ok) begin
      r_regs[reg_addr] <= reg_wdata;
    end
  end

  logic [CW-1:0] r_cnt;
  logic          r_tick;

  // Tick is registered one count early so it lines up with C_LAST.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= (r_cnt == C_LAST) ? '0 : r_cnt + 1'b1;
      r_tick <= (r_cnt == C_PRE);
    end
  end

  assign baud_tick = r_tick;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [FIFO_AW-1:0]    r_wr_ptr;
  logic [FIFO_AW-1:0]    r_rd_ptr;
  logic                  r_empty;
  logic                  r_full;
  logic                  w_pop;
  logic                  w_push;
  logic [FIFO_AW-1:0]    w_wr_nxt;
  logic [FIFO_AW-1:0]    w_rd_nxt;

  assign w_pop    = rd && !r_empty;
  assign w_push   = wr && (!r_full || w_pop);
  assign w_wr_nxt = r_wr_ptr + 1'b1;
  assign w_rd_nxt = r_rd_ptr + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= write_data;
        r_wr_ptr        <= w_wr_nxt;
      end
      if (w_pop)
        r_rd_ptr <= w_rd_nxt;
      if (w_push && !w_pop) begin
        r_empty <= 1'b0;
        if (w_wr_nxt == r_rd_ptr)
          r_full <= 1'b1;
      end else if (w_pop && !w_push) begin
        r_full <= 1'b0;
        if (w_rd_nxt == r_wr_ptr)
          r_empty <= 1'b1;
      end
    end
  end

  assign read_data = r_mem[r_rd_ptr];
  assign empty     = r_empty;
  assign full      = r_full;

endmodule

// File: tb/tb_uart2wifi_core_infra.sv
// Directed bench for uart2wifi_core_infra with a queue
// scoreboard for the FIFO.
module tb_uart2wifi_core_infra;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_write;
  logic        reg_read;
  logic [31:0] reg_rdata;
  logic        baud_tick;
  logic        wr;
  logic        rd;
  logic [7:0]  write_data;
  logic [7:0]  read_data;
  logic        empty;
  logic        full;

  int errors = 0;
  int checks = 0;
  logic [7:0] q[$];

  always #5 clk = ~clk;

  uart2wifi_core_infra dut (
    .clk        (clk),
    .rst        (rst),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_write  (reg_write),
    .reg_read   (reg_read),
    .reg_rdata  (reg_rdata),
    .baud_tick  (baud_tick),
    .wr         (wr),
    .rd         (rd),
    .write_data (write_data),
    .read_data  (read_data),
    .empty      (empty),
    .full       (full)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic fop(input logic w, input logic r,
                     input logic [7:0] d);
    logic       p;
    logic       u;
    logic [7:0] e;
    @(negedge clk);
    wr = w; rd = r; write_data = d;
    p = r && (q.size() > 0);
    u = w && ((q.size() < 16) || p);
    if (p) begin
      e = q.pop_front();
      chk("fifo_head", {24'b0, read_data}, {24'b0, e});
    end
    if (u) q.push_back(d);
    @(posedge clk);
    #1;
    wr = 1'b0; rd = 1'b0;
    chk("fifo_empty", {31'b0, empty}, {31'b0, q.size() == 0});
    chk("fifo_full", {31'b0, full}, {31'b0, q.size() == 16});
  endtask

  task automatic reg_wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    reg_addr = a; reg_wdata = d; reg_write = 1'b1;
    @(posedge clk);
    #1;
    reg_write = 1'b0;
  endtask

  task automatic reg_chk(input string tag, input logic [1:0] a,
                         input logic [31:0] exp);
    @(negedge clk);
    reg_addr = a; reg_read = 1'b1;
    #1;
    chk(tag, reg_rdata, exp);
    reg_read = 1'b0;
  endtask

  // Call right after reset release at a negedge: cycle 1 is the current one.
  task automatic baud_measure(input string tag);
    int cyc;
    int n;
    cyc = 1;
    chk({tag, "_tick_low"}, {31'b0, baud_tick}, 32'd0);
    while (!baud_tick && cyc < 400) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({tag, "_first"}, cyc, 32'd163);
    @(posedge clk);
    #1;
    chk({tag, "_width"}, {31'b0, baud_tick}, 32'd0);
    n = 1;
    while (!baud_tick && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_period"}, n, 32'd163);
    @(posedge clk);
    #1;
    chk({tag, "_width2"}, {31'b0, baud_tick}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    reg_addr = '0; reg_wdata = '0;
    reg_write = 1'b0; reg_read = 1'b0;
    wr = 1'b0; rd = 1'b0; write_data = '0;
    #1;
    reg_read = 1'b1;
    #1;
    chk("rst_rdata", reg_rdata, 32'd0);
    reg_read = 1'b0;
    chk("rst_empty", {31'b0, empty}, 32'd1);
    chk("rst_full", {31'b0, full}, 32'd0);
    chk("rst_read_data", {24'b0, read_data}, 32'd0);
    chk("rst_tick", {31'b0, baud_tick}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    baud_measure("baud");

    reg_wr(2'd0, 32'hDEADBEEF);
    reg_wr(2'd1, 32'h12345678);
    reg_wr(2'd2, 32'hA5A5A5A5);
    reg_chk("reg0", 2'd0, 32'hDEADBEEF);
    reg_chk("reg1", 2'd1, 32'h12345678);
    reg_chk("reg2", 2'd2, 32'hA5A5A5A5);
    reg_wr(2'd3, 32'hFFFFFFFF);
    reg_chk("reg3", 2'd3, 32'd0);
    reg_chk("reg0_keep", 2'd0, 32'hDEADBEEF);
    reg_chk("reg1_keep", 2'd1, 32'h12345678);
    reg_chk("reg2_keep", 2'd2, 32'hA5A5A5A5);
    @(negedge clk);
    reg_addr = 2'd1; reg_wdata = 32'hCAFEF00D;
    reg_write = 1'b1; reg_read = 1'b1;
    #1;
    chk("reg_rw_old", reg_rdata, 32'h12345678);
    @(posedge clk);
    #1;
    chk("reg_rw_new", reg_rdata, 32'hCAFEF00D);
    reg_write = 1'b0; reg_read = 1'b0;

    fop(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 21; i++)
      fop(1'b1, 1'b0, 8'(8'h04 + i));
    chk("fill_q16", q.size(), 32'd16);
    fop(1'b1, 1'b1, 8'h77);
    for (int i = 0; i < 16; i++)
      fop(1'b0, 1'b1, 8'h00);
    fop(1'b0, 1'b1, 8'h00);
    fop(1'b1, 1'b1, 8'h55);
    fop(1'b0, 1'b1, 8'h00);

    for (int i = 0; i < 8; i++)
      fop(1'b1, 1'b0, 8'(8'h20 + i));
    for (int i = 0; i < 8; i++)
      fop(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 12; i++)
      fop(1'b1, 1'b0, 8'(8'h40 + i));
    for (int i = 0; i < 12; i++)
      fop(1'b0, 1'b1, 8'h00);

    for (int i = 0; i < 5; i++)
      fop(1'b1, 1'b0, 8'(8'h90 + i));
    repeat (37) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    q.delete();
    chk("mid_empty", {31'b0, empty}, 32'd1);
    chk("mid_full", {31'b0, full}, 32'd0);
    chk("mid_read_data", {24'b0, read_data}, 32'd0);
    chk("mid_tick", {31'b0, baud_tick}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    baud_measure("baud_rst");
    reg_chk("rst_reg0", 2'd0, 32'd0);
    reg_chk("rst_reg1", 2'd1, 32'd0);
    reg_chk("rst_reg2", 2'd2, 32'd0);
    fop(1'b1, 1'b0, 8'h3C);
    fop(1'b0, 1'b1, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
